// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_pkg
// Purpose  : Shared types and constants for the register-file writeback stage.
//            XLEN/REG_AW/NREGS describe the 32x32 register file, wb_req_t is
//            one pending write (destination register + result data).
// Revision : 1.0  initial release
// ============================================================================
package rf_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // One-hot mask selecting a single register in a scoreboard vector.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
        return NREGS'(1) << a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous first-word-fall-through FIFO of wb_req_t entries.
//            The head entry is visible on o_head whenever o_empty is low.
//            Pushes into a full FIFO and pops from an empty one are ignored.
// Ports    : clk, rst        clock / synchronous active-high reset
//            i_push, i_req   write request and entry
//            i_pop           consume the head entry
//            o_head          current head entry
//            o_count         number of stored entries
//            o_full, o_empty occupancy flags (from registered count)
// Revision : 1.0  initial release
// ============================================================================
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  wb_req_t            i_req,
    input  logic               i_pop,
    output wb_req_t            o_head,
    output logic [c_CNT_W-1:0] o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_do_push;
    logic                 w_do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // Storage carries no reset: contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// Module   : rf_writeback
// Purpose  : Writeback stage driving the single register-file write port.
//            Merges in-order pipeline results (never refused, always win
//            arbitration) with long-latency results queued in a small FIFO.
//            Maintains the pending-register scoreboard, a sticky WAW error,
//            and a stall request when queued results keep losing arbitration.
// Ports    : clk, rst                    clock / synchronous active-high reset
//            pipe_wb_valid/addr/data     pipeline result
//            llu_valid/ready/addr/data   long-latency result handshake
//            issue_valid/addr            mark a register pending
//            pending                     scoreboard, bit i = xi outstanding
//            stall_req                   ask hazard unit to idle the pipeline
//            waw_err                     sticky: pipeline wrote a pending reg
//            rf_wr_en/addr/data          register-file write port
// Revision : 1.0  initial release
// ============================================================================
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wb_valid,
    input  logic [REG_AW-1:0] pipe_wb_addr,
    input  logic [XLEN-1:0]   pipe_wb_data,
    input  logic              llu_valid,
    output logic              llu_ready,
    input  logic [REG_AW-1:0] llu_addr,
    input  logic [XLEN-1:0]   llu_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_addr,
    output logic [NREGS-1:0]  pending,
    output logic              stall_req,
    output logic              waw_err,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [XLEN-1:0]   rf_wr_data
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    // ------------------------------------------------------------------
    // Long-latency FIFO
    // ------------------------------------------------------------------
    wb_req_t              w_llu_req;
    wb_req_t              w_head;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_push;
    logic                 w_pop;

    assign w_llu_req.addr = llu_addr;
    assign w_llu_req.data = llu_data;

    // Ready depends only on the registered occupancy, so a pop in the same
    // cycle never opens a slot early.
    assign llu_ready = (w_fifo_count < c_CNT_W'(DEPTH));
    // Same condition as llu_valid && llu_ready, phrased on the full flag.
    assign w_push    = llu_valid && !w_fifo_full;
    // Pipeline results cannot be held back, so the FIFO only drains on
    // cycles the pipeline leaves idle.
    assign w_pop     = !pipe_wb_valid && !w_fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_req   (w_llu_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic     w_sel_valid;
    wb_req_t  w_sel;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = '0;
        if (pipe_wb_valid) begin
            w_sel_valid = 1'b1;
            w_sel.addr  = pipe_wb_addr;
            w_sel.data  = pipe_wb_data;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel       = w_head;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and starvation tracking
    // ------------------------------------------------------------------
    logic [NREGS-1:0]   r_pending;
    logic [NREGS-1:0]   w_pending_nxt;
    logic [c_STV_W-1:0] r_starve;
    logic [c_STV_W-1:0] w_starve_nxt;
    logic               r_stall;
    logic               r_waw;
    logic               w_waw_hit;

    // Clear is applied before set so an issue to the register being retired
    // in the same cycle leaves it pending (the new op is still outstanding).
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt = w_pending_nxt & ~reg_onehot(w_head.addr);
        end
        if (issue_valid && (issue_addr != '0)) begin
            w_pending_nxt = w_pending_nxt | reg_onehot(issue_addr);
        end
    end

    // Counts cycles a waiting head loses to the pipeline; saturates at the
    // threshold so it cannot wrap back below it during a long pipeline burst.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_fifo_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (pipe_wb_valid && (r_starve < c_STV_W'(STARVE_MAX))) begin
            w_starve_nxt = r_starve + c_STV_W'(1);
        end
    end

    assign w_waw_hit = pipe_wb_valid && (pipe_wb_addr != '0) &&
                       r_pending[pipe_wb_addr];

    // ------------------------------------------------------------------
    // Output register and state update
    // ------------------------------------------------------------------
    logic              r_wr_en;
    logic [REG_AW-1:0] r_wr_addr;
    logic [XLEN-1:0]   r_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_pending <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_waw     <= 1'b0;
        end else begin
            // x0 results still consume their slot but never reach the file.
            r_wr_en <= w_sel_valid && (w_sel.addr != '0);
            if (w_sel_valid) begin
                r_wr_addr <= w_sel.addr;
                r_wr_data <= w_sel.data;
            end
            r_pending <= w_pending_nxt;
            r_starve  <= w_starve_nxt;
            r_stall   <= (w_starve_nxt >= c_STV_W'(STARVE_MAX));
            if (w_waw_hit) begin
                r_waw <= 1'b1;
            end
        end
    end

    assign rf_wr_en   = r_wr_en;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wr_data = r_wr_data;
    assign pending    = r_pending;
    assign stall_req  = r_stall;
    assign waw_err    = r_waw;

endmodule
`default_nettype wire
